// File: rtl/mux8t1_8_arb_if.sv
// Bus bundle for the mux8t1_8_arb round-robin arbiter.
//   req      : per-requester request, bit i belongs to xi
//   x0..x7   : requester data bytes
//   o_ready  : downstream accepts o when high together with o_valid
//   o        : registered output data
//   o_valid  : o holds a beat
//   sel      : index of the current or last grant
//   gnt      : one-hot grant, zero while idle
//   ack      : combinational one-cycle accept pulse to the grant owner
// master = requesters/downstream side, slave = arbiter side.
interface mux8t1_8_arb_if #(
  parameter int unsigned WIDTH = 8
);
  logic [7:0]       req;
  logic [WIDTH-1:0] x0;
  logic [WIDTH-1:0] x1;
  logic [WIDTH-1:0] x2;
  logic [WIDTH-1:0] x3;
  logic [WIDTH-1:0] x4;
  logic [WIDTH-1:0] x5;
  logic [WIDTH-1:0] x6;
  logic [WIDTH-1:0] x7;
  logic             o_ready;
  logic [WIDTH-1:0] o;
  logic             o_valid;
  logic [2:0]       sel;
  logic [7:0]       gnt;
  logic [7:0]       ack;

  modport master (
    output req, x0, x1, x2, x3, x4, x5, x6, x7, o_ready,
    input  o, o_valid, sel, gnt, ack
  );

  modport slave (
    input  req, x0, x1, x2, x3, x4, x5, x6, x7, o_ready,
    output o, o_valid, sel, gnt, ack
  );
endinterface

// File: rtl/mux8t1_8_arb.sv
// Round-robin arbiter and sequencer for the 8-to-1 mux datapath. Picks one
// requester, drives the mux select, captures the selected word into a
// registered output and hands it downstream with a valid/ready handshake.
// Ports:
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : mux8t1_8_arb_if.slave (req, x0..x7, o_ready in;
//            o, o_valid, sel, gnt, ack out; ack is combinational)
// Optional feature: define MUX_ARB_BURST_EN to let the owner keep the grant
// for up to BURST_MAX consecutive beats while it holds its request.
module mux8t1_8_arb #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  mux8t1_8_arb_if.slave    bus
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned SEL_W = 3;
  localparam int unsigned CNT_W = 4;

`ifdef MUX_ARB_BURST_EN
  localparam bit BURST_EN = 1'b1;
`else
  localparam bit BURST_EN = 1'b0;
`endif

  // Beats allowed per grant; a disabled feature is a cap of one beat.
  localparam int unsigned BURST_CAP = BURST_EN ? BURST_MAX : 1;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [WIDTH-1:0]   o_q, o_d;
  logic               o_valid_q, o_valid_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [SEL_W-1:0]   pick;
  logic               accept;
  logic               burst_more;
  logic               regrant;
  logic [WIDTH-1:0]   xv [N_REQ];

  assign xv[0] = bus.x0;
  assign xv[1] = bus.x1;
  assign xv[2] = bus.x2;
  assign xv[3] = bus.x3;
  assign xv[4] = bus.x4;
  assign xv[5] = bus.x5;
  assign xv[6] = bus.x6;
  assign xv[7] = bus.x7;

  assign accept = o_valid_q & bus.o_ready;

  // Owner keeps the grant if still requesting and under its beat cap.
  assign burst_more = bus.req[sel_q] && ((32'(cnt_q) + 32'd1) < BURST_CAP);

  // A nonzero count in IDLE means a burst is in progress for sel_q.
  assign regrant = (cnt_q != '0) && bus.req[sel_q];

  // Circular first-set search from ptr; walking downward lets the
  // lowest offset from ptr win.
  always_comb begin
    pick = ptr_q;
    for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
      if (bus.req[SEL_W'(ptr_q + SEL_W'(i))]) begin
        pick = SEL_W'(ptr_q + SEL_W'(i));
      end
    end
  end

`ifdef MUX_ARB_BURST_EN
  logic [CNT_W-1:0] cnt_d;

  // Burst counter: counts re-grants to the same owner.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && (|bus.req) && !regrant) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = burst_more ? CNT_W'(cnt_q + CNT_W'(1)) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign cnt_q = '0;
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    o_d       = o_q;
    o_valid_d = o_valid_q;
    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          sel_d     = regrant ? sel_q : pick;
          gnt_d     = N_REQ'(1) << sel_d;
          o_d       = xv[sel_d];
          o_valid_d = 1'b1;
          state_d   = XFER;
        end
      end
      XFER: begin
        // Captured beat, select and grant hold until accepted.
        if (accept) begin
          o_valid_d = 1'b0;
          gnt_d     = '0;
          state_d   = IDLE;
          if (!burst_more) begin
            ptr_d = SEL_W'(sel_q + SEL_W'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      o_q       <= '0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      o_q       <= o_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.o       = o_q;
  assign bus.o_valid = o_valid_q;
  assign bus.sel     = sel_q;
  assign bus.gnt     = gnt_q;
  assign bus.ack     = gnt_q & {N_REQ{accept}};

endmodule

// File: tb/tb_mux8t1_8_arb.sv
// Self-checking bench for mux8t1_8_arb: scenario tasks with a scoreboard of
// expected (sel, data) beats popped on every accept.
module tb_mux8t1_8_arb;

`ifdef MUX_ARB_BURST_EN
  localparam int BURST = 4;
`else
  localparam int BURST = 1;
`endif

  typedef struct packed {
    logic [2:0] sel;
    logic [7:0] data;
  } beat_t;

  logic  clk;
  logic  rst_n;
  int    n_tests;
  int    n_fail;
  beat_t exp_q[$];

  mux8t1_8_arb_if #(.WIDTH(8)) bus ();

  mux8t1_8_arb u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // xi = 8'hii
  task automatic drive_ramp();
    bus.x0 = 8'h00; bus.x1 = 8'h11; bus.x2 = 8'h22; bus.x3 = 8'h33;
    bus.x4 = 8'h44; bus.x5 = 8'h55; bus.x6 = 8'h66; bus.x7 = 8'h77;
  endtask

  function automatic beat_t mk_beat(input logic [2:0] s);
    beat_t b;
    b.sel  = s;
    b.data = {1'b0, s, 1'b0, s};
    return b;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 8'hFF;
    bus.o_ready = 1'b1;
    drive_ramp();
    repeat (2) @(negedge clk);
    n_tests++; if (bus.o !== 8'h00) begin n_fail++; $display("FAIL reset_o: got %h exp 00", bus.o); end
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b exp 0", bus.o_valid); end
    n_tests++; if (bus.sel !== 3'd0) begin n_fail++; $display("FAIL reset_sel: got %0d exp 0", bus.sel); end
    n_tests++; if (bus.gnt !== 8'h00) begin n_fail++; $display("FAIL reset_gnt: got %h exp 00", bus.gnt); end
    n_tests++; if (bus.ack !== 8'h00) begin n_fail++; $display("FAIL reset_ack: got %h exp 00", bus.ack); end
    bus.req = 8'h00;
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      n_tests++;
      if (bus.o_valid !== 1'b0 || bus.gnt !== 8'h00) begin
        n_fail++; $display("FAIL idle_after_reset: valid %b gnt %h exp 0 00", bus.o_valid, bus.gnt);
      end
    end
  endtask

  task automatic test_single();
    beat_t e;
    @(negedge clk);
    bus.x3 = 8'h33; bus.req = 8'h08; bus.o_ready = 1'b1;
    exp_q.push_back(mk_beat(3'd3));
    @(negedge clk);
    n_tests++; if (bus.sel !== 3'd3) begin n_fail++; $display("FAIL single_sel: got %0d exp 3", bus.sel); end
    n_tests++; if (bus.gnt !== 8'h08) begin n_fail++; $display("FAIL single_gnt: got %h exp 08", bus.gnt); end
    n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %b exp 1", bus.o_valid); end
    n_tests++; if (bus.ack !== 8'h08) begin n_fail++; $display("FAIL single_ack: got %h exp 08", bus.ack); end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL single_sb: accept with empty scoreboard");
    end else begin
      e = exp_q.pop_front();
      if (bus.o !== e.data || bus.sel !== e.sel) begin
        n_fail++; $display("FAIL single_beat: got sel %0d o %h exp sel %0d o %h", bus.sel, bus.o, e.sel, e.data);
      end
    end
    bus.req = 8'h00;
    @(negedge clk);
    n_tests++; if (bus.ack !== 8'h00) begin n_fail++; $display("FAIL single_ack_once: got %h exp 00", bus.ack); end
    n_tests++; if (bus.o_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop: got %b exp 0", bus.o_valid); end
  endtask

  task automatic test_rotation();
    beat_t      e;
    logic [7:0] exp_ack;
    int         got;
    int         last_cyc;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_ramp();
    bus.o_ready = 1'b1;
    bus.req = 8'hFF;
    for (int k = 0; k < 9; k++) exp_q.push_back(mk_beat(3'((k / BURST) % 8)));
    got = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 60 && got < 9; cyc++) begin
      @(negedge clk);
      if (bus.ack !== 8'h00) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rot_sb: accept with empty scoreboard");
        end else begin
          e = exp_q.pop_front();
          exp_ack = 8'h01 << e.sel;
          if (bus.o !== e.data || bus.sel !== e.sel || bus.ack !== exp_ack) begin
            n_fail++;
            $display("FAIL rot_beat%0d: got sel %0d o %h ack %h exp sel %0d o %h ack %h",
                     got, bus.sel, bus.o, bus.ack, e.sel, e.data, exp_ack);
          end
        end
        if (last_cyc >= 0) begin
          n_tests++;
          if (cyc - last_cyc != 2) begin
            n_fail++; $display("FAIL rot_spacing: got %0d cycles exp 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
        if (got == 9) bus.req = 8'h00;
      end
    end
    n_tests++;
    if (got != 9) begin n_fail++; $display("FAIL rot_count: got %0d beats exp 9", got); end
    bus.req = 8'h00;
  endtask

  task automatic test_backpressure();
    beat_t e;
    @(negedge clk);
    bus.x5 = 8'h55; bus.req = 8'h20; bus.o_ready = 1'b0;
    exp_q.push_back(mk_beat(3'd5));
    @(negedge clk);
    n_tests++;
    if (bus.o !== 8'h55 || bus.o_valid !== 1'b1 || bus.sel !== 3'd5 || bus.gnt !== 8'h20 || bus.ack !== 8'h00) begin
      n_fail++; $display("FAIL bp_grant: got o %h v %b sel %0d gnt %h ack %h exp 55 1 5 20 00",
                         bus.o, bus.o_valid, bus.sel, bus.gnt, bus.ack);
    end
    bus.x5 = 8'hAA;
    repeat (5) begin
      @(negedge clk);
      n_tests++;
      if (bus.o !== 8'h55 || bus.o_valid !== 1'b1 || bus.sel !== 3'd5 || bus.ack !== 8'h00) begin
        n_fail++; $display("FAIL bp_hold: got o %h v %b sel %0d ack %h exp 55 1 5 00",
                           bus.o, bus.o_valid, bus.sel, bus.ack);
      end
    end
    bus.o_ready = 1'b1;
    #1;
    n_tests++; if (bus.ack !== 8'h20) begin n_fail++; $display("FAIL bp_ack: got %h exp 20", bus.ack); end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL bp_sb: accept with empty scoreboard");
    end else begin
      e = exp_q.pop_front();
      if (bus.o !== e.data || bus.sel !== e.sel) begin
        n_fail++; $display("FAIL bp_beat: got sel %0d o %h exp sel %0d o %h", bus.sel, bus.o, e.sel, e.data);
      end
    end
    bus.req = 8'h00;
    bus.x5 = 8'h55;
    @(negedge clk);
    n_tests++;
    if (bus.ack !== 8'h00 || bus.o_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_ack_once: got ack %h v %b exp 00 0", bus.ack, bus.o_valid);
    end
  endtask

  task automatic test_burst();
    beat_t      e;
    logic [2:0] seq [$];
    int         n_exp;
    int         got;
    int         last_cyc;
`ifdef MUX_ARB_BURST_EN
    seq = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0};
`else
    seq = '{3'd0, 3'd2, 3'd0, 3'd2};
`endif
    n_exp = seq.size();
    @(negedge clk);
    bus.o_ready = 1'b1;
    bus.req = 8'h05;
    foreach (seq[k]) exp_q.push_back(mk_beat(seq[k]));
    got = 0;
    last_cyc = -1;
    for (int cyc = 0; cyc < 60 && got < n_exp; cyc++) begin
      @(negedge clk);
      if (bus.ack !== 8'h00) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL burst_sb: accept with empty scoreboard");
        end else begin
          e = exp_q.pop_front();
          if (bus.o !== e.data || bus.sel !== e.sel) begin
            n_fail++; $display("FAIL burst_beat%0d: got sel %0d o %h exp sel %0d o %h",
                               got, bus.sel, bus.o, e.sel, e.data);
          end
        end
        if (last_cyc >= 0) begin
          n_tests++;
          if (cyc - last_cyc != 2) begin
            n_fail++; $display("FAIL burst_spacing: got %0d cycles exp 2", cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        got++;
        if (got == n_exp) bus.req = 8'h00;
      end
    end
    n_tests++;
    if (got != n_exp) begin n_fail++; $display("FAIL burst_count: got %0d beats exp %0d", got, n_exp); end
    bus.req = 8'h00;
  endtask

  task automatic test_reset_mid();
    beat_t e;
    @(negedge clk);
    bus.req = 8'h10; bus.o_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.o_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_valid: got %b exp 1", bus.o_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.gnt !== 8'h00 || bus.o !== 8'h00 || bus.sel !== 3'd0 || bus.ack !== 8'h00) begin
      n_fail++; $display("FAIL rmid_async: got v %b gnt %h o %h sel %0d ack %h exp 0 00 00 0 00",
                         bus.o_valid, bus.gnt, bus.o, bus.sel, bus.ack);
    end
    bus.o_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.ack !== 8'h00) begin n_fail++; $display("FAIL rmid_no_ack: got %h exp 00", bus.ack); end
    drive_ramp();
    bus.req = 8'hFF;
    rst_n = 1'b1;
    exp_q.push_back(mk_beat(3'd0));
    @(negedge clk);
    n_tests++;
    if (bus.gnt !== 8'h01 || bus.ack !== 8'h01) begin
      n_fail++; $display("FAIL rmid_first_grant: got gnt %h ack %h exp 01 01", bus.gnt, bus.ack);
    end
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++; $display("FAIL rmid_sb: accept with empty scoreboard");
    end else begin
      e = exp_q.pop_front();
      if (bus.o !== e.data || bus.sel !== e.sel) begin
        n_fail++; $display("FAIL rmid_beat: got sel %0d o %h exp sel %0d o %h", bus.sel, bus.o, e.sel, e.data);
      end
    end
    bus.req = 8'h00;
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus.req = 8'h00;
    bus.o_ready = 1'b0;
    drive_ramp();
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_burst();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL sb_drain: %0d beats never delivered, exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux8t1_8_arb.md
# mux8t1_8_arb

Round-robin arbiter and sequencer for the 8-to-1, 8-bit mux datapath. Eight requesters each present a data byte and a request. The block picks one, drives the mux `sel`, and captures the selected byte into a registered output with a valid/ready handshake. It sits in front of the shared output bus and is the only driver of `sel`.

## Interface
- `WIDTH`, default 8: data width of `x0`..`x7` and `o`.
- `BURST_MAX`, default 4: maximum consecutive beats per grant. Only used when `MUX_ARB_BURST_EN` is defined. Legal range 1..16.

Ports:
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req`  in  8: per-requester request, bit i belongs to `xi`.
- `x0`..`x7`  in  WIDTH each: requester data.
- `o_ready`  in  1: downstream accepts `o` when high with `o_valid`.
- `o`  out  WIDTH: registered output data.
- `o_valid`  out  1: `o` holds a beat.
- `sel`  out  3: index of the current or last grant (mux select).
- `gnt`  out  8: one-hot grant. Zero in IDLE.
- `ack`  out  8: combinational, `gnt & {8{o_valid & o_ready}}`. One-cycle accept pulse to the owner.

## Operation
- Two states: IDLE and XFER. Reset state is IDLE.
- Priority pointer `ptr` (3 bits) resets to 0.
- **IDLE:**
  - If `req` is 0, stay in IDLE. `o_valid` = 0, `gnt` = 0.
  - Otherwise pick the first set bit of `req`, searching circularly from `ptr` upward (wraps 7 to 0).
  - At the next edge: `sel` <= idx, `gnt` <= 1<<idx, `o` <= x[idx], `o_valid` <= 1, state <= XFER.
- **XFER:**
  - While `o_ready` is 0, `o`, `o_valid`, `sel` and `gnt` hold. Changes on `x*` and `req` are ignored.
  - On the edge where `o_valid` & `o_ready`: beat is accepted, `ack[sel]` is high that cycle.
  - Then `o_valid` <= 0, `gnt` <= 0, `ptr` <= sel+1 (mod 8), state <= IDLE.
- Requester protocol:
  - Hold `req` high and `xi` stable from request until `ack[i]`.
  - Update `xi`, or drop `req`, on the `ack` edge.
  - Dropping `req` before `ack` does not cancel the beat. The captured byte is still delivered.
- `sel` keeps its last value in IDLE. It changes only at a grant edge.
- Every requester with `req` held is served within 8 grants (no starvation) when the burst feature is off.

## Timing
- **Reset values:** `o` = 0, `o_valid` = 0, `sel` = 0, `gnt` = 0, `ptr` = 0, burst count = 0. `ack` = 0 follows from these.
- **Latency:** `req` is sampled high in IDLE at edge k. `o_valid` and `gnt` are high after edge k. The earliest `ack` is in the cycle after edge k.
- **Throughput:** one mandatory IDLE cycle follows each accept. With `o_ready` tied high and continuous requests, one beat every 2 cycles.
- **Simultaneous events:**
  - A new `req` arriving in the accept cycle is considered in the following IDLE cycle.
  - Requests arriving in the accept cycle are evaluated against the updated `ptr`.
- **Reset mid-XFER:** all registers clear immediately (asynchronous). The in-flight beat is discarded and no `ack` is issued.

## Configuration
- `MUX_ARB_BURST_EN` defined:
  - A 4-bit burst counter is compiled in.
  - On accept, if `req[sel]` is still high and count < BURST_MAX-1: go to IDLE for one cycle, then re-grant the same `sel` and capture the fresh `x[sel]`. `ptr` is unchanged; count increments.
  - Otherwise `ptr` <= sel+1 and count <= 0.
  - A requester receives at most BURST_MAX consecutive beats.
- Not defined:
  - No counter is present.
  - `ptr` advances after every accept, i.e. behaviour is identical to BURST_MAX = 1.

## Test plan
- **Reset:** assert `rst_n` = 0 with `req` = 8'hFF.
  - Expect `o` = 0, `o_valid` = 0, `sel` = 0, `gnt` = 0.
  - After release with `req` = 0, expect the block to stay idle for 10 cycles with `o_valid` = 0.
- **Single requester:** `x3` = 8'h33, `req` = 8'h08, `o_ready` = 1.
  - One edge later: `sel` = 3, `gnt` = 8'h08, `o` = 8'h33, `o_valid` = 1.
  - `ack` = 8'h08 for exactly one cycle, then `o_valid` = 0.
- **Full rotation, macro off:** `xi` = 8'hii (8'h00..8'h77), `req` = 8'hFF, `o_ready` = 1.
  - Expect `o` = 00, 11, 22, …, 77, 00 on successive accepts, 2 cycles apart.
  - `sel` follows 0..7 then wraps to 0.
- **Backpressure:** `o_ready` = 0 for 5 cycles after a grant to requester 5 (`x5` = 8'h55), and change `x5` to 8'hAA meanwhile.
  - Expect `o` = 8'h55, `o_valid` = 1, `sel` = 5 stable throughout.
  - On `o_ready` = 1, `ack[5]` pulses once.
- **Burst:** `req` = 8'h05, `o_ready` = 1.
  - With `MUX_ARB_BURST_EN` and BURST_MAX = 4, expect grant sequence 0,0,0,0,2,2,2,2,0.
  - Without the macro, expect 0,2,0,2.
- **Reset mid-transfer:** drive `rst_n` low while `o_valid` = 1 and `o_ready` = 0.
  - Expect `o_valid`, `gnt`, `o` and `sel` at 0 without waiting for a clock edge, and no `ack`.
  - After release with `req` = 8'hFF, the first grant goes to requester 0.
